// File: rtl/hwag_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwag_decoder_pkg
// Description : Shared types and constants for the one-hot strobe decoder.
//               Holds the controller state encoding and the pulse counter
//               width so every file agrees on them.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hwag_decoder_pkg;

   // Controller states, explicitly 1 bit wide.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STROBE = 1'b1
   } state_e;

   // Pulse counter width; the strobe length range 1..255 fits in 8 bits.
   localparam int C_CNT_W = 8;

   // Converts a pulse length into the terminal count of the pulse counter.
   function automatic logic [C_CNT_W-1:0] f_last_count(input int pulse_len);
      return C_CNT_W'(pulse_len - 1);
   endfunction

endpackage : hwag_decoder_pkg
`default_nettype wire

// File: rtl/onehot_decode.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decode
// Description : Purely combinational binary to one-hot decoder.
// Ports       : code   - W-bit binary input
//               onehot - 2**W-bit one-hot output, bit[code] set
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode #(
   parameter int W = 4
) (
   input  logic [W-1:0]      code,
   output logic [2**W-1:0]   onehot
);

   generate
      for (genvar i = 0; i < 2**W; i++) begin : g_bit
         assign onehot[i] = (code == W'(i));
      end
   endgenerate

endmodule : onehot_decode
`default_nettype wire

// File: rtl/onehot_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_strobe_decoder
// Description : Accepts a start address (and optionally an inclusive end
//               address) through a valid/ready handshake and strobes the
//               one-hot decode of each address for PULSE_LEN clocks. The full
//               decode, the row decode (address MSBs) and the column decode
//               (address LSBs) are all registered.
// Ports       : clk      - clock, rising edge
//               n_rst    - asynchronous active-low reset
//               in_valid - request present
//               in_ready - request can be accepted
//               in_addr  - start address
//               in_scan  - 0: single strobe, 1: scan in_addr..in_end
//               in_end   - inclusive scan end address
//               abort    - terminate current operation, blocks acceptance
//               onehot   - one-hot of current address
//               row      - one-hot of address MSBs
//               column   - one-hot of address LSBs
//               busy     - not idle
//               done     - one-clock pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_strobe_decoder
   import hwag_decoder_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int ROW_W     = 4,
   parameter int PULSE_LEN = 1
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_W-1:0]               in_addr,
   input  logic                          in_scan,
   input  logic [IN_W-1:0]               in_end,
   input  logic                          abort,
   output logic [2**IN_W-1:0]            onehot,
   output logic [2**ROW_W-1:0]           row,
   output logic [2**(IN_W-ROW_W)-1:0]    column,
   output logic                          busy,
   output logic                          done
);

   localparam int               C_COL_W = IN_W - ROW_W;
   localparam logic [C_CNT_W-1:0] C_LAST = f_last_count(PULSE_LEN);

   state_e                    r_state;
   state_e                    w_next_state;
   logic [C_CNT_W-1:0]        r_cnt;
   logic [C_CNT_W-1:0]        w_next_cnt;
   logic [IN_W-1:0]           r_addr;
   logic [IN_W-1:0]           w_next_addr;
   logic [IN_W-1:0]           r_end;
   logic [IN_W-1:0]           w_next_end;
   logic                      r_scan;
   logic                      w_next_scan;
   logic                      r_done;

   logic [2**IN_W-1:0]        r_onehot;
   logic [2**ROW_W-1:0]       r_row;
   logic [2**C_COL_W-1:0]     r_column;

   logic [2**IN_W-1:0]        w_dec_full;
   logic [2**ROW_W-1:0]       w_dec_row;
   logic [2**C_COL_W-1:0]     w_dec_col;

   logic                      w_ready;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_final;
   logic                      w_complete;

   assign w_accept   = in_valid & w_ready;
   assign w_last     = (r_cnt == C_LAST);
   // Current address is the last one of the operation.
   assign w_final    = ~r_scan | (r_addr == r_end);
   // Abort takes priority, so an aborted final strobe gives no done.
   assign w_complete = (r_state == ST_STROBE) & ~abort & w_last & w_final;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (abort || (w_last && w_final)) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic (state-derived)
   // ------------------------------------------------------------------
   always_comb begin
      w_ready = (r_state == ST_IDLE) & ~abort;
      busy    = (r_state != ST_IDLE);
   end

   assign in_ready = w_ready;

   // ------------------------------------------------------------------
   // Address / counter next values
   // ------------------------------------------------------------------
   always_comb begin
      w_next_cnt  = r_cnt;
      w_next_addr = r_addr;
      w_next_end  = r_end;
      w_next_scan = r_scan;
      if (w_accept) begin
         w_next_addr = in_addr;
         w_next_end  = in_end;
         w_next_scan = in_scan;
         w_next_cnt  = '0;
      end else if ((r_state == ST_STROBE) && !abort) begin
         if (w_last) begin
            w_next_cnt = '0;
            if (!w_final) begin
               // Natural wrap of the IN_W-bit add gives modulo 2**IN_W.
               w_next_addr = r_addr + 1'b1;
            end
         end else begin
            w_next_cnt = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt  <= '0;
         r_addr <= '0;
         r_end  <= '0;
         r_scan <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= w_next_cnt;
         r_addr <= w_next_addr;
         r_end  <= w_next_end;
         r_scan <= w_next_scan;
         r_done <= w_complete;
      end
   end

   // ------------------------------------------------------------------
   // Decoders look at the next address so the registered outputs line up
   // with the state register: they show the decode of the latched address
   // in every STROBE cycle, starting the clock after the handshake.
   // ------------------------------------------------------------------
   onehot_decode #(.W(IN_W)) u_dec_full (
      .code   (w_next_addr),
      .onehot (w_dec_full)
   );

   onehot_decode #(.W(ROW_W)) u_dec_row (
      .code   (w_next_addr[IN_W-1 -: ROW_W]),
      .onehot (w_dec_row)
   );

   onehot_decode #(.W(C_COL_W)) u_dec_col (
      .code   (w_next_addr[C_COL_W-1:0]),
      .onehot (w_dec_col)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_onehot <= '0;
         r_row    <= '0;
         r_column <= '0;
      end else if (w_next_state == ST_STROBE) begin
         r_onehot <= w_dec_full;
         r_row    <= w_dec_row;
         r_column <= w_dec_col;
      end else begin
         r_onehot <= '0;
         r_row    <= '0;
         r_column <= '0;
      end
   end

   assign onehot = r_onehot;
   assign row    = r_row;
   assign column = r_column;
   assign done   = r_done;

endmodule : onehot_strobe_decoder
`default_nettype wire

// File: tb/tb_onehot_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_strobe_decoder
// Description : Self-checking bench. Two instances: one with default
//               parameters, one with PULSE_LEN=3. Expected strobe addresses
//               are queued when a request is driven and compared per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_strobe_decoder;

   logic          clk = 1'b0;
   logic          n_rst;
   logic [1:0]    in_valid;
   logic [1:0]    in_ready;
   logic [7:0]    in_addr;
   logic          in_scan;
   logic [7:0]    in_end;
   logic          abort;
   logic [255:0]  oh   [2];
   logic [15:0]   rw   [2];
   logic [15:0]   cl   [2];
   logic [1:0]    busy;
   logic [1:0]    done;

   int            n_checks = 0;
   int            n_errors = 0;
   int            sel      = 0;
   int            exp_q[$];

   always #5 clk = ~clk;

   onehot_strobe_decoder #(.IN_W(8), .ROW_W(4), .PULSE_LEN(1)) dut1 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_addr(in_addr), .in_scan(in_scan), .in_end(in_end), .abort(abort),
      .onehot(oh[0]), .row(rw[0]), .column(cl[0]), .busy(busy[0]), .done(done[0])
   );

   onehot_strobe_decoder #(.IN_W(8), .ROW_W(4), .PULSE_LEN(3)) dut3 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_addr(in_addr), .in_scan(in_scan), .in_end(in_end), .abort(abort),
      .onehot(oh[1]), .row(rw[1]), .column(cl[1]), .busy(busy[1]), .done(done[1])
   );

   typedef struct {
      int         inst;
      logic [7:0] a;
      logic       s;
      logic [7:0] e;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Queue the expected strobe sequence for one request.
   task automatic push_exp(input logic [7:0] a, input logic s, input logic [7:0] e);
      logic [7:0] cur;
      int         plen;
      plen = (sel == 1) ? 3 : 1;
      cur  = a;
      for (int k = 0; k < 256; k++) begin
         for (int p = 0; p < plen; p++) exp_q.push_back(int'(cur));
         if (!s || cur == e) break;
         cur = cur + 8'd1;
      end
   endtask

   // Called just after a rising edge; handshake completes at the next edge.
   task automatic start_req(input logic [7:0] a, input logic s, input logic [7:0] e);
      in_addr = a; in_scan = s; in_end = e;
      in_valid[sel] = 1'b1;
      @(negedge clk);
      chk("ready before request", 256'(in_ready[sel]), 256'(1));
      chk("done low before request", 256'(done[sel]), 256'(0));
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
      push_exp(a, s, e);
   endtask

   // Compare every queued strobe cycle, then the done cycle.
   task automatic drain();
      int a;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         a = exp_q.pop_front();
         chk("strobe onehot", oh[sel], 256'(1) << a);
         chk("strobe row", 256'(rw[sel]), 256'(1) << (a >> 4));
         chk("strobe column", 256'(cl[sel]), 256'(1) << (a & 15));
         chk("strobe busy", 256'(busy[sel]), 256'(1));
         chk("no early done", 256'(done[sel]), 256'(0));
      end
      @(negedge clk);
      chk("done pulse", 256'(done[sel]), 256'(1));
      chk("idle busy", 256'(busy[sel]), 256'(0));
      chk("idle onehot", oh[sel], 256'(0));
      chk("idle row/column", 256'({rw[sel], cl[sel]}), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b0; in_valid = '0; in_addr = '0; in_scan = 1'b0;
      in_end = '0; abort = 1'b0;
      vecs[0] = '{0, 8'h5A, 1'b0, 8'h00};
      vecs[1] = '{0, 8'h10, 1'b1, 8'h12};
      vecs[2] = '{1, 8'h10, 1'b1, 8'h12};
      vecs[3] = '{0, 8'hFE, 1'b1, 8'h01};
      vecs[4] = '{1, 8'h33, 1'b0, 8'h00};
      vecs[5] = '{0, 8'h07, 1'b1, 8'h07};
      vecs[6] = '{0, 8'hFF, 1'b1, 8'h00};

      // Reset state
      #13;
      for (int i = 0; i < 2; i++) begin
         chk("reset onehot", oh[i], 256'(0));
         chk("reset row/column", 256'({rw[i], cl[i]}), 256'(0));
         chk("reset busy/done", 256'({busy[i], done[i]}), 256'(0));
      end
      @(negedge clk); n_rst = 1'b1;
      @(negedge clk);
      chk("ready after reset", 256'(in_ready), 256'(2'b11));

      // Table-driven requests
      for (int v = 0; v < 7; v++) begin
         @(posedge clk); #1;
         sel = vecs[v].inst;
         start_req(vecs[v].a, vecs[v].s, vecs[v].e);
         drain();
      end

      // New request accepted in the done cycle
      @(posedge clk); #1;
      sel = 0;
      start_req(8'h20, 1'b0, 8'h00);
      drain();
      chk("ready in done cycle", 256'(in_ready[0]), 256'(1));
      in_addr = 8'h21; in_scan = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      push_exp(8'h21, 1'b0, 8'h00);
      drain();

      // Abort at second address, then abort blocking acceptance in IDLE
      @(posedge clk); #1;
      start_req(8'h00, 1'b1, 8'h0F);
      exp_q.delete();
      @(negedge clk);
      chk("abort seq addr0", oh[0], 256'(1));
      @(posedge clk); #1; abort = 1'b1;
      @(negedge clk);
      chk("abort seq addr1", oh[0], 256'(2));
      @(posedge clk); #1;
      in_valid[0] = 1'b1; in_addr = 8'h44; in_scan = 1'b0;
      @(negedge clk);
      chk("abort outputs zero", oh[0], 256'(0));
      chk("abort busy/done", 256'({busy[0], done[0]}), 256'(0));
      chk("abort blocks ready", 256'(in_ready[0]), 256'(0));
      @(posedge clk); #1;
      abort = 1'b0; in_valid[0] = 1'b0;
      @(negedge clk);
      chk("abort no accept", 256'(busy[0]), 256'(0));
      chk("abort no done", 256'(done[0]), 256'(0));
      chk("ready after abort", 256'(in_ready[0]), 256'(1));

      // in_valid while busy is ignored; held request taken in done cycle
      @(posedge clk); #1;
      sel = 1;
      start_req(8'h10, 1'b1, 8'h12);
      in_valid[1] = 1'b1; in_addr = 8'h99; in_scan = 1'b0; in_end = 8'h98;
      drain();
      chk("held req ready", 256'(in_ready[1]), 256'(1));
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      push_exp(8'h99, 1'b0, 8'h00);
      drain();

      // Reset mid-scan
      @(posedge clk); #1;
      sel = 0;
      start_req(8'h00, 1'b1, 8'h0F);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b0;
      #1;
      chk("async reset onehot", oh[0], 256'(0));
      chk("async reset row/column", 256'({rw[0], cl[0]}), 256'(0));
      chk("async reset busy/done", 256'({busy[0], done[0]}), 256'(0));
      @(posedge clk); #1 n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post reset busy/done", 256'({busy[0], done[0]}), 256'(0));
         chk("post reset onehot", oh[0], 256'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_onehot_strobe_decoder
`default_nettype wire
